// File: rtl/rv32_inst_encoder.sv
// rv32_inst_encoder
//   RV32I instruction encoder for the debug/bootload path. Field bundles are
//   range-checked and packed into 32-bit instruction words. Legal words go into
//   a small FIFO and are then written one at a time into the instruction RAM.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle pulse in IDLE: clear counters/err, begin a program
//   in_valid/in_ready/in_last   field-bundle handshake, last-of-program flag
//   fmt,op,fn3,fn7,rd,rs1,rs2,imm   instruction fields (fmt 0..5 = R,I,S,B,U,J)
//   ram_stall     RAM cannot take a write this cycle
//   ram_we/ram_addr/ram_wdata   registered RAM write port
//   busy, done    FSM not idle / one-cycle program-complete pulse
//   err           sticky field-range or address-overflow error
//   word_cnt      words written since start
module rv32_inst_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        fmt,
  input  logic [6:0]        op,
  input  logic [2:0]        fn3,
  input  logic [6:0]        fn7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  input  logic              ram_stall,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [31:0]       mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       count;
  logic [ADDR_W-1:0] ld_cnt;   // words loaded into the output register
  logic [ADDR_W:0]   res_cnt;  // legal words accepted (capacity reservation)

  logic [31:0] enc_word;
  logic        enc_bad;
  logic        is_shift;
  logic        fifo_empty, fifo_full;
  logic        ovf, cap_full;
  logic        accept, push, pop, wr_done;

  // Encoder and range checker
  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    is_shift = (op == 7'b0010011) && ((fn3 == 3'b001) || (fn3 == 3'b101));
    case (fmt)
      3'd0: enc_word = {fn7, rs2, rs1, fn3, rd, op};
      3'd1: begin
        if (is_shift) begin
          enc_word = {fn7, imm[4:0], rs1, fn3, rd, op};
          enc_bad  = |imm[31:5];
        end else begin
          enc_word = {imm[11:0], rs1, fn3, rd, op};
          enc_bad  = !((&imm[31:11]) || !(|imm[31:11]));
        end
      end
      3'd2: begin
        enc_word = {imm[11:5], rs2, rs1, fn3, imm[4:0], op};
        enc_bad  = !((&imm[31:11]) || !(|imm[31:11]));
      end
      3'd3: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, fn3, imm[4:1], imm[11], op};
        enc_bad  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
      3'd4: begin
        enc_word = {imm[31:12], rd, op};
        enc_bad  = |imm[11:0];
      end
      3'd5: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        enc_bad  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
      default: enc_bad = 1'b1;
    endcase
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign ovf        = word_cnt[ADDR_W];
  // Stop accepting once every remaining RAM address is already claimed, so
  // nothing queued can ever be written past the top of the address space.
  assign cap_full   = res_cnt[ADDR_W];

  assign in_ready = (state == S_RUN) && !fifo_full && !ovf && !cap_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && !enc_bad;
  assign wr_done  = ram_we[0] && !ram_stall;
  // The output register refills whenever it is empty or its word retires now.
  assign pop      = !fifo_empty && (!ram_we[0] || !ram_stall);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN: begin
        if (ovf)                     state_n = S_FLUSH;
        else if (accept && in_last)  state_n = S_FLUSH;
      end
      S_FLUSH: if (fifo_empty && !ram_we[0]) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      ld_cnt    <= '0;
      res_cnt   <= '0;
      ram_we    <= '0;
      ram_addr  <= BASE;
      ram_wdata <= '0;
      word_cnt  <= '0;
      err       <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      ld_cnt   <= '0;
      res_cnt  <= '0;
      ram_we   <= '0;
      ram_addr <= BASE;
      word_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (push) begin
        wptr    <= wptr + 1'b1;
        res_cnt <= res_cnt + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (pop) begin
        ram_we    <= '1;
        ram_wdata <= mem[rptr];
        ram_addr  <= BASE + ld_cnt;
        ld_cnt    <= ld_cnt + 1'b1;
      end else if (wr_done) begin
        ram_we <= '0;
      end
      if (wr_done) word_cnt <= word_cnt + 1'b1;
      if ((accept && enc_bad) || ovf) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32_inst_encoder.sv
// Testbench for rv32_inst_encoder (DEPTH=4, ADDR_W=3, BASE_ADDR=0).
module tb_rv32_inst_encoder;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, in_last;
  logic [2:0]  fmt, fn3;
  logic [6:0]  op, fn7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        ram_stall;
  logic [3:0]  ram_we;
  logic [2:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        busy, done, err;
  logic [3:0]  word_cnt;

  rv32_inst_encoder #(.DEPTH(4), .ADDR_W(3), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .fmt(fmt), .op(op), .fn3(fn3),
    .fn7(fn7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .ram_stall(ram_stall), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .busy(busy), .done(done), .err(err),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: legality from integer ranges, encoding from field layout
  function automatic bit m_legal(input logic [2:0] f, input logic [6:0] o,
                                 input logic [2:0] f3, input logic [31:0] im);
    int s;
    s = $signed(im);
    case (f)
      3'd0: return 1'b1;
      3'd1: if (o == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) return im < 32;
            else return (s >= -2048) && (s <= 2047);
      3'd2: return (s >= -2048) && (s <= 2047);
      3'd3: return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      3'd4: return (im % 4096) == 0;
      3'd5: return (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_enc(input logic [2:0] f, input logic [6:0] o,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
    case (f)
      3'd0: return {f7, s2, s1, f3, d, o};
      3'd1: if (o == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) return {f7, im[4:0], s1, f3, d, o};
            else return {im[11:0], s1, f3, d, o};
      3'd2: return {im[11:5], s2, s1, f3, im[4:0], o};
      3'd3: return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], o};
      3'd4: return {im[31:12], d, o};
      3'd5: return {im[20], im[10:1], im[11], im[19:12], d, o};
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] m_q[$];
  int          m_wc;
  bit          m_err;
  int          done_cnt = 0;
  logic [31:0] wr_data[16];
  int          wr_addr[16];
  int          wr_n = 0;
  bit          prev_hold = 0;
  logic [3:0]  prev_we;
  logic [2:0]  prev_addr;
  logic [31:0] prev_data;

  // Single compare process
  always @(negedge clk) begin
    if (rst) begin
      m_q.delete();
      m_wc = 0;
      m_err = 0;
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_we", {28'd0, ram_we}, {28'd0, prev_we});
        chk("hold_addr", {29'd0, ram_addr}, {29'd0, prev_addr});
        chk("hold_data", ram_wdata, prev_data);
      end
      if (ram_we == 4'hF && !ram_stall) begin
        if (m_q.size() == 0) begin
          chk("spurious_write", {29'd0, ram_addr}, 32'hFFFFFFFF);
        end else begin
          chk("wr_data", ram_wdata, m_q.pop_front());
          chk("wr_addr", {29'd0, ram_addr}, m_wc);
        end
        chk("wr_cnt", {28'd0, word_cnt}, m_wc);
        if (wr_n < 16) begin
          wr_data[wr_n] = ram_wdata;
          wr_addr[wr_n] = int'(ram_addr);
          wr_n++;
        end
        m_wc++;
        if (m_wc == 8) m_err = 1;
      end
      prev_hold = (ram_we == 4'hF) && ram_stall;
      prev_we   = ram_we;
      prev_addr = ram_addr;
      prev_data = ram_wdata;
      if (in_valid && in_ready) begin
        if (m_legal(fmt, op, fn3, imm)) m_q.push_back(m_enc(fmt, op, fn3, fn7, rd, rs1, rs2, imm));
        else m_err = 1;
      end
      if (done) begin
        done_cnt++;
        chk("done_q_empty", m_q.size(), 0);
        chk("done_word_cnt", {28'd0, word_cnt}, m_wc);
        chk("done_err", {31'd0, err}, {31'd0, m_err});
        chk("done_we", {28'd0, ram_we}, 0);
      end
      if (start && !busy) begin
        m_q.delete();
        m_wc = 0;
        m_err = 0;
        wr_n = 0;
      end
    end
  end

  bit rand_stall = 0;
  bit stall_force = 0;
  always @(posedge clk) begin
    #2;
    ram_stall = rand_stall ? ($urandom_range(0, 3) == 0) : stall_force;
  end

  task automatic push(input logic [2:0] f, input logic [6:0] o, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im, input bit last,
                      input int budget, output bit ok);
    fmt = f; op = o; fn3 = f3; fn7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_last = last;
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic push_add(input logic [4:0] d, input bit last, input int budget, output bit ok);
    push(3'd0, 7'h33, 3'd0, 7'd0, d, 5'd1, 5'd2, 32'd0, last, budget, ok);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int dc, input int budget, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = (done_cnt != dc);
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic gen_push(input bit last);
    logic [2:0] f, f3;
    logic [6:0] o, f7;
    logic [4:0] d, s1, s2;
    logic [31:0] im;
    bit good, ok;
    f  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    o  = 7'($urandom); f3 = 3'($urandom); f7 = 7'($urandom);
    d  = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
    im = $urandom;
    good = ($urandom_range(0, 3) != 0);
    if (good) begin
      case (f)
        3'd1: if ($urandom_range(0, 1) == 1) begin
                o = 7'h13;
                f3 = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
                im = 32'($urandom_range(0, 31));
              end else im = 32'($urandom_range(0, 4095)) - 32'd2048;
        3'd2: im = 32'($urandom_range(0, 4095)) - 32'd2048;
        3'd3: im = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
        3'd4: im = $urandom & 32'hFFFFF000;
        3'd5: im = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
        default: ;
      endcase
    end
    push(f, o, f3, f7, d, s1, s2, im, last, 200, ok);
    chk("rand_accept", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    bit ok;
    int dc, acc;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    fmt = '0; op = '0; fn3 = '0; fn7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_we", {28'd0, ram_we}, 0);
    chk("rst_addr", {29'd0, ram_addr}, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_word_cnt", {28'd0, word_cnt}, 0);
    @(posedge clk);
    #1;

    // ADDI x1,x0,-1 with latency check
    do_start();
    dc = done_cnt;
    push(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 20, ok);
    chk("t1_accept", {31'd0, ok}, 1);
    chk("t1_we_before", {28'd0, ram_we}, 0);
    @(posedge clk);
    #1;
    chk("t1_we", {28'd0, ram_we}, 32'hF);
    chk("t1_wdata", ram_wdata, 32'hFFF00093);
    chk("t1_addr", {29'd0, ram_addr}, 0);
    wait_done(dc, 50, "t1_done_seen");
    chk("t1_word_cnt", {28'd0, word_cnt}, 1);
    chk("t1_done_pulse", {31'd0, done}, 0);
    chk("t1_busy", {31'd0, busy}, 0);

    // SW, BEQ, JAL in order
    do_start();
    dc = done_cnt;
    push(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 20, ok);
    push(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 20, ok);
    push(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 20, ok);
    wait_done(dc, 50, "t2_done_seen");
    chk("t2_n", wr_n, 3);
    chk("t2_w0", wr_data[0], 32'h0020A423);
    chk("t2_w1", wr_data[1], 32'hFE208EE3);
    chk("t2_w2", wr_data[2], 32'h001000EF);
    chk("t2_a2", wr_addr[2], 2);

    // Illegal BEQ / LUI dropped, ADD written
    do_start();
    dc = done_cnt;
    push(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 20, ok);
    push(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, 1'b0, 20, ok);
    push(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 20, ok);
    wait_done(dc, 50, "t3_done_seen");
    chk("t3_err", {31'd0, err}, 1);
    chk("t3_n", wr_n, 1);
    chk("t3_w0", wr_data[0], 32'h002081B3);
    chk("t3_a0", wr_addr[0], 0);

    // Back-pressure: 5 accepts under stall, then release
    do_start();
    dc = done_cnt;
    stall_force = 1;
    @(posedge clk);
    #1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      push_add(5'(i + 1), 1'b0, 20, ok);
      if (ok) acc++;
    end
    chk("t4_acc5", acc, 5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t4_ready_low", {31'd0, in_ready}, 0);
    chk("t4_we_held", {28'd0, ram_we}, 32'hF);
    @(posedge clk);
    #1;
    stall_force = 0;
    push_add(5'd6, 1'b1, 20, ok);
    chk("t4_acc6", {31'd0, ok}, 1);
    wait_done(dc, 50, "t4_done_seen");
    chk("t4_n", wr_n, 6);
    for (int i = 0; i < 6; i++) chk("t4_addr", wr_addr[i], i);
    chk("t4_w5", wr_data[5], 32'h00208333);

    // Address-space overflow with ADDR_W=3
    do_start();
    dc = done_cnt;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      push_add(5'(i + 1), (i == 9), 20, ok);
      if (ok) acc++;
    end
    chk("t5_acc", acc, 8);
    chk("t5_ready", {31'd0, in_ready}, 0);
    wait_done(dc, 50, "t5_done_seen");
    chk("t5_n", wr_n, 8);
    chk("t5_err", {31'd0, err}, 1);
    chk("t5_word_cnt", {28'd0, word_cnt}, 8);
    chk("t5_last_addr", wr_addr[7], 7);

    // Reset during FLUSH with words queued
    do_start();
    stall_force = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) push_add(5'(i + 1), (i == 2), 20, ok);
    @(negedge clk);
    chk("t6_busy_flush", {31'd0, busy}, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_we", {28'd0, ram_we}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_word_cnt", {28'd0, word_cnt}, 0);
    chk("t6_ready", {31'd0, in_ready}, 0);
    rst = 1'b0;
    stall_force = 0;
    @(posedge clk);
    #1;
    do_start();
    dc = done_cnt;
    push(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 20, ok);
    wait_done(dc, 50, "t6_done_seen");
    chk("t6_n", wr_n, 1);
    chk("t6_addr", wr_addr[0], 0);
    chk("t6_w0", wr_data[0], 32'hFFF00093);

    // Randomized programs with random stalls
    rand_stall = 1;
    for (int p = 0; p < 12; p++) begin
      int n;
      do_start();
      dc = done_cnt;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) gen_push(i == n - 1);
      wait_done(dc, 400, "rand_done_seen");
    end
    rand_stall = 0;

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv32_inst_encoder.md
Name: rv32_inst_encoder

Overview:
- RV32I instruction encoder: the inverse of the pipeline's instruction decoder.
- Accepts instruction fields (format, opcode, Fn3, Fn7, register indices, immediate), range-checks them and packs them into 32-bit words.
- Buffers words in a small FIFO and writes them sequentially into the instruction RAM's write port.
- Used by the debug/bootload path to load programs into instruction memory before the CPU is released from reset.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- ADDR_W, 12, instruction-RAM word-address width
- BASE_ADDR, 0, first word address written after start

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse in IDLE: clear counters/err, enter RUN
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept bundle
- in_last  input  1  bundle is last of program
- fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
- op  input  7  opcode
- fn3  input  3  funct3
- fn7  input  7  funct7
- rd, rs1, rs2  input  5 each  register indices
- imm  input  32  signed byte immediate (U: full 32-bit value)
- ram_stall  input  1  RAM cannot take a write this cycle
- ram_we  output  4  byte write enables, 4'b1111 or 0
- ram_addr  output  ADDR_W  word address
- ram_wdata  output  32  encoded word
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at program completion
- err  output  1  sticky field/overflow error
- word_cnt  output  ADDR_W+1  words written since start

Behaviour:
- Reset: state=IDLE; FIFO empty; in_ready=0, ram_we=0, ram_addr=BASE_ADDR, ram_wdata=0, busy=0, done=0, err=0, word_cnt=0. rst mid-program aborts immediately with no further writes.
- FSM:
  - IDLE -start-> RUN.
  - RUN: in_ready = !fifo_full && !ovf. On an accepted bundle with in_last=1 -> FLUSH.
  - FLUSH: in_ready=0; when FIFO empty and no write in flight -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - start outside IDLE is ignored.
- Encoding (combinational on inputs, pushed at the accept edge):
  - R: fn7|rs2|rs1|fn3|rd|op.
  - I: imm[11:0]|rs1|fn3|rd|op. Exception: op=0010011 with fn3=001/101 uses fn7|imm[4:0]|rs1|fn3|rd|op.
  - S: imm[11:5]|rs2|rs1|fn3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|fn3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Range checks:
  - I/S: imm must be in signed 12-bit range.
  - Shift-I: imm[31:5]==0.
  - B: signed 13-bit range and imm[0]=0.
  - J: signed 21-bit range and imm[0]=0.
  - U: imm[11:0]=0.
  - fmt 6/7: illegal.
  - On any violation: bundle is still accepted (and in_last still honoured), the word is NOT pushed, err set sticky.
- Write stage: registered outputs.
  - When FIFO non-empty and ram_stall=0: pop the head; next cycle ram_we=1111, ram_wdata=word, ram_addr=BASE_ADDR+word_cnt; word_cnt increments on that cycle.
  - If ram_stall=1 while ram_we=1111: all ram_* outputs hold and nothing is popped.
  - Minimum latency, empty FIFO and no stall: bundle accepted at edge k -> ram_we=1111 during cycle k+2.
  - Throughput: 1 word/cycle.
- Simultaneous push and pop on a full FIFO: not allowed, since in_ready=0 when full.
- Overflow: once word_cnt reaches 2^ADDR_W, set ovf and err and drop in_ready. An in_last bundle pending at that point is not accepted; the FSM goes to FLUSH directly. Addresses never wrap.
- word_cnt and err persist after done until the next start.

Test Plan:
- rst, start, push ADDI x1,x0,-1 (fmt=1, op=0010011, fn3=0, rd=1, imm=-1), in_last=1 -> ram_wdata=32'hFFF00093, ram_addr=0, we=1111 two cycles after accept; done pulses; word_cnt=1.
- Push SW x2,8(x1) then BEQ x1,x2,-4 then JAL x1,2048 -> words 32'h0020A423, 32'hFE208EE3, 32'h001000EF at addresses 0,1,2, in order.
- Push BEQ imm=3 (odd), then LUI imm=32'h12345001, then valid ADD x3,x1,x2 -> first two dropped, err=1, only 32'h002081B3 written at address 0.
- Hold ram_stall=1 while pushing 6 bundles with DEPTH=4 -> in_ready falls after 5 accepts (4 in FIFO + 1 in output reg); release -> 6 words written, addresses 0..5 consecutive, none lost or duplicated.
- ADDR_W=3, push 10 bundles -> 8 words written, ovf/err set, in_ready=0, FSM completes with done pulse, no write to address 0 again.
- Assert rst during FLUSH with 2 words queued -> next cycle ram_we=0, busy=0, word_cnt=0; subsequent start reloads from BASE_ADDR.
